// File: rtl/multiplier_5by5_pkg.sv
// Shared widths, FSM states and helpers for the 5x5 shift-add multiplier.
package mul_pkg;

  localparam int WORD_W = 5;
  localparam int PROD_W = 10;
  localparam int CNT_W  = 3;
  localparam logic [CNT_W-1:0] ITER_LAST = 3'd4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    MULT,
    OUT_HI,
    OUT_LO
  } mulState_t;

  // Magnitude of a two's complement word; -16 maps to 5'b10000, which the unsigned core handles.
  function automatic logic [WORD_W-1:0] magOf(input logic [WORD_W-1:0] w);
    return w[WORD_W-1] ? (~w + 1'b1) : w;
  endfunction

endpackage

// File: rtl/multiplier_5by5_if.sv
// Serial 5-bit word bus shared with the 10-by-5 divider: host drives operands, block returns product words.
interface multiplier_5by5_if;
  import mul_pkg::*;

  logic [WORD_W-1:0] dataIN;
  logic              start;
  logic              busy;
  logic              done;
  logic [WORD_W-1:0] dataOUT;

  modport master (output dataIN, output start, input busy, input done, input dataOUT);
  modport slave  (input dataIN, input start, output busy, output done, output dataOUT);

endinterface

// File: rtl/multiplier_5by5_shift_add_core.sv
// Operand registers, iteration counter and shift-add accumulator.
// With MUL_SIGNED_EN defined, operands are stored as magnitudes and the product sign is fixed on output.
module shift_add_core
  import mul_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              loadA,
  input  logic              loadB,
  input  logic              step,
  input  logic [WORD_W-1:0] dataIn,
  output logic              iterLast,
  output logic [PROD_W-1:0] product
);

  logic [WORD_W-1:0] regA;
  logic [WORD_W-1:0] regB;
  logic [PROD_W-1:0] accP;
  logic [CNT_W-1:0]  count;
  logic [WORD_W-1:0] operandIn;

`ifdef MUL_SIGNED_EN
  logic signA;
  logic signB;

  assign operandIn = magOf(dataIn);

  always_ff @(posedge clk) begin
    if (rst) begin
      signA <= 1'b0;
      signB <= 1'b0;
    end else begin
      if (loadA) signA <= dataIn[WORD_W-1];
      if (loadB) signB <= dataIn[WORD_W-1];
    end
  end

  // Negation happens on the way out so the core stays purely unsigned and no cycle is added.
  assign product = (signA ^ signB) ? (~accP + 1'b1) : accP;
`else
  assign operandIn = dataIn;
  assign product   = accP;
`endif

  // LOAD_B clears the accumulator, so the previous product lingers until the next operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      regA  <= '0;
      regB  <= '0;
      accP  <= '0;
      count <= '0;
    end else begin
      if (loadA) regA <= operandIn;
      if (loadB) begin
        regB  <= operandIn;
        accP  <= '0;
        count <= '0;
      end else if (step) begin
        if (regB[count]) accP <= accP + (PROD_W'(regA) << count);
        count <= count + 1'b1;
      end
    end
  end

  assign iterLast = (count == ITER_LAST);

endmodule

// File: rtl/multiplier_5by5.sv
// Sequential 5x5 shift-add multiplier: FSM and output decode around shift_add_core.
// Optional signed operands via `define MUL_SIGNED_EN.
module multiplier_5by5
  import mul_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  multiplier_5by5_if.slave  bus
);

  mulState_t state;
  mulState_t nextState;

  logic              loadA;
  logic              loadB;
  logic              step;
  logic              iterLast;
  logic [PROD_W-1:0] product;
  logic              busyInt;
  logic              doneInt;
  logic [WORD_W-1:0] dataOutInt;

  shift_add_core core (
    .clk      (clk),
    .rst      (rst),
    .loadA    (loadA),
    .loadB    (loadB),
    .step     (step),
    .dataIn   (bus.dataIN),
    .iterLast (iterLast),
    .product  (product)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // Outputs depend only on state and registered product, never directly on bus inputs.
  always_comb begin
    nextState  = state;
    loadA      = 1'b0;
    loadB      = 1'b0;
    step       = 1'b0;
    busyInt    = 1'b1;
    doneInt    = 1'b0;
    dataOutInt = '0;
    unique case (state)
      IDLE: begin
        busyInt = 1'b0;
        if (bus.start) nextState = LOAD_A;
      end
      LOAD_A: begin
        loadA     = 1'b1;
        nextState = LOAD_B;
      end
      LOAD_B: begin
        loadB     = 1'b1;
        nextState = MULT;
      end
      MULT: begin
        step = 1'b1;
        if (iterLast) nextState = OUT_HI;
      end
      OUT_HI: begin
        doneInt    = 1'b1;
        dataOutInt = product[PROD_W-1:WORD_W];
        nextState  = OUT_LO;
      end
      OUT_LO: begin
        doneInt    = 1'b1;
        dataOutInt = product[WORD_W-1:0];
        nextState  = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  assign bus.busy    = busyInt;
  assign bus.done    = doneInt;
  assign bus.dataOUT = dataOutInt;

endmodule
